// File: rtl/res_seq_pkg.sv
// Shared state encoding, size codes and mode normalisation for the
// resolution-mode sequencer.
package res_seq_pkg;

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      IDLE     = 3'd1,
      ALIGN    = 3'd2,
      RESEND   = 3'd3,
      CFG_WAIT = 3'd4,
      FLUSH    = 3'd5,
      SHOW     = 3'd6
   } seq_state_t;

   localparam logic [1:0] SIZE_640 = 2'b00;
   localparam logic [1:0] SIZE_320 = 2'b01;
   localparam logic [1:0] SIZE_160 = 2'b10;

   localparam int unsigned TMO_W     = 22;
   localparam int unsigned FRAME_W   = 4;
   localparam int unsigned RS_W      = 8;
   localparam int unsigned RETRY_MAX = 2;

   // The unused 11 button combination is served as the smallest mode.
   function automatic logic [1:0] normalise(input logic [1:0] mode);
      case (mode)
         SIZE_640, SIZE_320, SIZE_160: return mode;
         default:                      return SIZE_160;
      endcase
   endfunction

endpackage

// File: rtl/sync_edge.sv
// N-stage level synchroniser followed by an edge detector producing
// single-cycle rise/fall pulses. STAGES=0 bypasses the synchroniser for
// signals already in the clk domain.
module sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic prev_d;
   logic prev_q;

   generate
      if (STAGES == 0) begin : g_direct
         assign level = din;
      end else begin : g_sync
         logic [STAGES-1:0] sync_d;
         logic [STAGES-1:0] sync_q;

         // Shift the asynchronous input through the synchroniser chain.
         always_comb begin
            sync_d[0] = din;
            for (int unsigned i = 1; i < STAGES; i++) begin
               sync_d[i] = sync_q[i-1];
            end
         end

         // Synchroniser flops.
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= {STAGES{RST_VAL}};
            end else begin
               sync_q <= sync_d;
            end
         end

         assign level = sync_q[STAGES-1];
      end
   endgenerate

   // Previous-level next state for the edge detector.
   always_comb begin
      prev_d = level;
   end

   // Edge detector history flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= RST_VAL;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = level & ~prev_q;
   assign fall = ~level & prev_q;

endmodule

// File: rtl/res_mode_sequencer.sv
// Resolution-mode sequencer: aligns size changes to VGA frame boundaries,
// gates capture/display, pulses camera reconfiguration and re-enables the
// display once SETTLE_FRAMES clean camera frames have been written.
// Optional macro RES_SEQ_CFG_TIMEOUT_EN adds a config timeout with retries
// and a sticky cfg_error output.
module res_mode_sequencer
   import res_seq_pkg::*;
#(
   parameter int unsigned SETTLE_FRAMES = 2,
   parameter int unsigned RESEND_LEN    = 4,
   parameter int unsigned CFG_TIMEOUT   = 2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode_req,
   input  logic       vga_vsync,
   input  logic       cam_vsync,
   input  logic       config_finished,
   output logic [1:0] size_select,
   output logic       capture_en,
   output logic       display_en,
   output logic       resend,
   output logic       busy
`ifdef RES_SEQ_CFG_TIMEOUT_EN
   ,
   output logic       cfg_error
`endif
);

   localparam logic [TMO_W-1:0]   TMO_LIMIT  = TMO_W'(CFG_TIMEOUT);
   localparam logic [RS_W-1:0]    RS_LAST    = RS_W'(RESEND_LEN - 1);
   localparam logic [FRAME_W:0]   SETTLE_CNT = (FRAME_W+1)'(SETTLE_FRAMES);

   logic cam_level, cam_fs, cam_fe;
   logic cfg_sync, cfg_rise, cfg_fall;
   logic vga_level, vga_rise, vga_fs;

   seq_state_t         state_d, state_q;
   logic [1:0]         size_d, size_q;
   logic [1:0]         pending_d, pending_q;
   logic               cap_d, cap_q;
   logic               disp_d, disp_q;
   logic               resend_d, resend_q;
   logic               busy_d, busy_q;
   logic [RS_W-1:0]    rs_cnt_d, rs_cnt_q;
   logic [FRAME_W-1:0] frame_cnt_d, frame_cnt_q;
   logic               seen_low_d, seen_low_q;
`ifdef RES_SEQ_CFG_TIMEOUT_EN
   logic [TMO_W-1:0]   tmo_cnt_d, tmo_cnt_q;
   logic [1:0]         retry_d, retry_q;
   logic               err_d, err_q;
`endif

   sync_edge #(.STAGES(2), .RST_VAL(1'b0)) u_cam_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (cam_vsync),
      .level (cam_level),
      .rise  (cam_fs),
      .fall  (cam_fe)
   );

   sync_edge #(.STAGES(2), .RST_VAL(1'b0)) u_cfg_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (config_finished),
      .level (cfg_sync),
      .rise  (cfg_rise),
      .fall  (cfg_fall)
   );

   sync_edge #(.STAGES(0), .RST_VAL(1'b1)) u_vga_edge (
      .clk   (clk),
      .rst   (rst),
      .din   (vga_vsync),
      .level (vga_level),
      .rise  (vga_rise),
      .fall  (vga_fs)
   );

   logic unused_sigs;
`ifdef RES_SEQ_CFG_TIMEOUT_EN
   assign unused_sigs = ^{vga_level, vga_rise, cam_level};
`else
   assign unused_sigs = ^{vga_level, vga_rise, cam_level, TMO_LIMIT};
`endif

   // Next-state and next-output logic for the sequencing FSM.
   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      pending_d   = normalise(mode_req);
      cap_d       = cap_q;
      disp_d      = disp_q;
      resend_d    = resend_q;
      rs_cnt_d    = rs_cnt_q;
      frame_cnt_d = frame_cnt_q;
      seen_low_d  = seen_low_q;
`ifdef RES_SEQ_CFG_TIMEOUT_EN
      retry_d     = retry_q;
      err_d       = err_q;
      tmo_cnt_d   = tmo_cnt_q;
      if ((state_q == INIT || state_q == CFG_WAIT) && (tmo_cnt_q != '1)) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
`endif

      unique case (state_q)
         INIT: begin
            if (cfg_sync) begin
               cap_d       = 1'b0;
               frame_cnt_d = '0;
               state_d     = FLUSH;
            end
`ifdef RES_SEQ_CFG_TIMEOUT_EN
            else if (tmo_cnt_q >= TMO_LIMIT) begin
               err_d       = 1'b1;
               cap_d       = 1'b0;
               frame_cnt_d = '0;
               state_d     = FLUSH;
            end
`endif
         end

         IDLE: begin
            cap_d  = 1'b1;
            disp_d = 1'b1;
            if (pending_q != size_q) begin
               state_d = ALIGN;
            end
         end

         ALIGN: begin
            if (vga_fs) begin
               disp_d   = 1'b0;
               cap_d    = 1'b0;
               size_d   = pending_q;
               resend_d = 1'b1;
               rs_cnt_d = '0;
`ifdef RES_SEQ_CFG_TIMEOUT_EN
               retry_d  = '0;
`endif
               state_d  = RESEND;
            end
         end

         RESEND: begin
            if (rs_cnt_q == RS_LAST) begin
               resend_d   = 1'b0;
               // A config line already low on entry counts as the fall.
               seen_low_d = ~cfg_sync;
`ifdef RES_SEQ_CFG_TIMEOUT_EN
               tmo_cnt_d  = '0;
`endif
               state_d    = CFG_WAIT;
            end else begin
               rs_cnt_d = rs_cnt_q + 1'b1;
            end
         end

         CFG_WAIT: begin
            if (cfg_fall) begin
               seen_low_d = 1'b1;
            end
            if (seen_low_q && cfg_rise) begin
               frame_cnt_d = '0;
               state_d     = FLUSH;
            end
`ifdef RES_SEQ_CFG_TIMEOUT_EN
            else if (tmo_cnt_q >= TMO_LIMIT) begin
               if (retry_q < 2'(RETRY_MAX)) begin
                  retry_d  = retry_q + 1'b1;
                  resend_d = 1'b1;
                  rs_cnt_d = '0;
                  state_d  = RESEND;
               end else begin
                  err_d       = 1'b1;
                  frame_cnt_d = '0;
                  state_d     = FLUSH;
               end
            end
`endif
         end

         FLUSH: begin
            if (!cap_q) begin
               if (cam_fs) begin
                  cap_d       = 1'b1;
                  frame_cnt_d = '0;
               end
            end else if (cam_fe) begin
               if (frame_cnt_q != '1) begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
               if (({1'b0, frame_cnt_q} + 1'b1) >= SETTLE_CNT) begin
                  state_d = SHOW;
               end
            end
         end

         SHOW: begin
            if (vga_fs) begin
               disp_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = INIT;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         size_q      <= SIZE_640;
         pending_q   <= SIZE_640;
         cap_q       <= 1'b0;
         disp_q      <= 1'b0;
         resend_q    <= 1'b0;
         busy_q      <= 1'b1;
         rs_cnt_q    <= '0;
         frame_cnt_q <= '0;
         seen_low_q  <= 1'b0;
`ifdef RES_SEQ_CFG_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         retry_q     <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         pending_q   <= pending_d;
         cap_q       <= cap_d;
         disp_q      <= disp_d;
         resend_q    <= resend_d;
         busy_q      <= busy_d;
         rs_cnt_q    <= rs_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         seen_low_q  <= seen_low_d;
`ifdef RES_SEQ_CFG_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         retry_q     <= retry_d;
         err_q       <= err_d;
`endif
      end
   end

   assign size_select = size_q;
   assign capture_en  = cap_q;
   assign display_en  = disp_q;
   assign resend      = resend_q;
   assign busy        = busy_q;
`ifdef RES_SEQ_CFG_TIMEOUT_EN
   assign cfg_error   = err_q;
`endif

endmodule

// File: tb/tb_res_mode_sequencer.sv
// Self-checking bench for res_mode_sequencer. Expected committed sizes are
// queued when mode_req is driven and popped when size_select changes.
// With RES_SEQ_CFG_TIMEOUT_EN the config timeout/retry path is also exercised.
module tb_res_mode_sequencer;

`ifdef RES_SEQ_CFG_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 1000;
`else
   localparam int unsigned TB_TIMEOUT = 2500000;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode_req;
   logic       vga_vsync;
   logic       cam_vsync;
   logic       config_finished;
   logic [1:0] size_select;
   logic       capture_en;
   logic       display_en;
   logic       resend;
   logic       busy;
`ifdef RES_SEQ_CFG_TIMEOUT_EN
   logic       cfg_error;
`endif

   logic       cam_run = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [1:0] exp_q[$];

   int cyc = 0;
   int vga_fall_total = 0, last_vga_fall_cyc = -1000;
   int cam_rise_total = 0, last_cam_rise_cyc = -1000;
   int cam_fall_total = 0, last_cam_fall_cyc = -1000;
   logic vga_prev = 1'b1, cam_prev = 1'b0;

   res_mode_sequencer #(
      .SETTLE_FRAMES (2),
      .RESEND_LEN    (4),
      .CFG_TIMEOUT   (TB_TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .mode_req        (mode_req),
      .vga_vsync       (vga_vsync),
      .cam_vsync       (cam_vsync),
      .config_finished (config_finished),
      .size_select     (size_select),
      .capture_en      (capture_en),
      .display_en      (display_en),
      .resend          (resend),
      .busy            (busy)
`ifdef RES_SEQ_CFG_TIMEOUT_EN
      ,
      .cfg_error       (cfg_error)
`endif
   );

   always #20 clk = ~clk;

   // VGA vsync: 200-cycle frame, active-low for 10 cycles.
   initial begin
      vga_vsync = 1'b1;
      forever begin
         repeat (190) @(negedge clk);
         vga_vsync = 1'b0;
         repeat (10) @(negedge clk);
         vga_vsync = 1'b1;
      end
   end

   // Camera vsync: 150-cycle frame, active-high for 8 cycles, only when enabled.
   initial begin
      cam_vsync = 1'b0;
      forever begin
         @(negedge clk);
         if (cam_run) begin
            cam_vsync = 1'b1;
            repeat (8) @(negedge clk);
            cam_vsync = 1'b0;
            repeat (141) @(negedge clk);
         end
      end
   end

   // Event tracker on the bench's own input waveforms.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (vga_prev && !vga_vsync) begin
         vga_fall_total    <= vga_fall_total + 1;
         last_vga_fall_cyc <= cyc + 1;
      end
      if (!cam_prev && cam_vsync) begin
         cam_rise_total    <= cam_rise_total + 1;
         last_cam_rise_cyc <= cyc + 1;
      end
      if (cam_prev && !cam_vsync) begin
         cam_fall_total    <= cam_fall_total + 1;
         last_cam_fall_cyc <= cyc + 1;
      end
      vga_prev <= vga_vsync;
      cam_prev <= cam_vsync;
   end

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog: simulation did not finish, got hang expected completion");
      $fatal(1);
   end

   function automatic logic pick(input int sel);
      case (sel)
         0:       return capture_en;
         1:       return display_en;
         2:       return resend;
         default: return busy;
      endcase
   endfunction

   task automatic wait_level(input int sel, input logic val, input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (pick(sel) === val) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_size(input logic [1:0] old, input int budget, output logic ok,
                            output logic saw_resend);
      ok = 1'b0;
      saw_resend = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (size_select !== old) begin
            ok = 1'b1;
            break;
         end
         if (resend) saw_resend = 1'b1;
      end
   endtask

   task automatic measure_resend(output int width);
      width = 0;
      while (resend === 1'b1 && width < 300) begin
         width++;
         @(negedge clk);
      end
   endtask

   task automatic cfg_handshake();
      config_finished = 1'b0;
      repeat (20) @(negedge clk);
      config_finished = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mode_req = 2'b00;
      config_finished = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (size_select !== 2'b00) begin n_fail++; $display("FAIL reset_size: got %b expected 00", size_select); end
      n_checks++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL reset_capture: got %b expected 0", capture_en); end
      n_checks++; if (display_en !== 1'b0) begin n_fail++; $display("FAIL reset_display: got %b expected 0", display_en); end
      n_checks++; if (resend !== 1'b0) begin n_fail++; $display("FAIL reset_resend: got %b expected 0", resend); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
`ifdef RES_SEQ_CFG_TIMEOUT_EN
      n_checks++; if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_error: got %b expected 0", cfg_error); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_bringup();
      logic ok, size_bad;
      int base_rise, base_fall, fall2_cyc;
      repeat (100) @(negedge clk);
      n_checks++; if (capture_en !== 1'b0 || display_en !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL init_wait: got cap=%b disp=%b busy=%b expected 0 0 1", capture_en, display_en, busy); end
      config_finished = 1'b1;
      repeat (10) @(negedge clk);
      n_checks++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL flush_no_frame: got %b expected 0", capture_en); end
      base_rise = cam_rise_total;
      base_fall = cam_fall_total;
      cam_run = 1'b1;
      wait_level(0, 1'b1, 60, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL capture_rise: got timeout expected capture_en=1"); end
      n_checks++; if (cam_rise_total !== base_rise + 1 || cyc - last_cam_rise_cyc > 4) begin
         n_fail++; $display("FAIL capture_first_fs: got rises=%0d lat=%0d expected 1 and <=4",
                            cam_rise_total - base_rise, cyc - last_cam_rise_cyc); end
      fall2_cyc = -1;
      size_bad = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (size_select !== 2'b00) size_bad = 1'b1;
         if (fall2_cyc < 0 && cam_fall_total >= base_fall + 2) fall2_cyc = last_cam_fall_cyc;
         if (display_en === 1'b1) begin ok = 1'b1; break; end
      end
      n_checks++; if (!ok) begin n_fail++; $display("FAIL display_rise: got timeout expected display_en=1"); end
      n_checks++; if (fall2_cyc < 0 || last_vga_fall_cyc <= fall2_cyc || cyc - last_vga_fall_cyc > 2) begin
         n_fail++; $display("FAIL display_align: got fall2=%0d vga=%0d now=%0d expected vga after fall2, within 2",
                            fall2_cyc, last_vga_fall_cyc, cyc); end
      n_checks++; if (size_bad) begin n_fail++; $display("FAIL bringup_size: got change expected 00 throughout"); end
   endtask

   task automatic test_mode_change();
      logic ok, saw;
      logic [1:0] exp;
      int width;
      mode_req = 2'b01;
      exp_q.push_back(2'b01);
      wait_size(2'b00, 600, ok, saw);
      exp = exp_q.pop_front();
      n_checks++; if (!ok || size_select !== exp) begin n_fail++; $display("FAIL commit_320: got %b expected %b", size_select, exp); end
      n_checks++; if (saw) begin n_fail++; $display("FAIL early_resend: got resend before commit expected none"); end
      n_checks++; if (cyc - last_vga_fall_cyc > 2) begin n_fail++; $display("FAIL commit_align: got %0d cycles after vga_fs expected <=2", cyc - last_vga_fall_cyc); end
      n_checks++; if (display_en !== 1'b0 || capture_en !== 1'b0) begin
         n_fail++; $display("FAIL commit_gating: got disp=%b cap=%b expected 0 0", display_en, capture_en); end
      measure_resend(width);
      n_checks++; if (width != 4) begin n_fail++; $display("FAIL resend_width: got %0d expected 4", width); end
      cfg_handshake();
      wait_level(3, 1'b0, 1500, ok);
      n_checks++; if (!ok || display_en !== 1'b1 || capture_en !== 1'b1) begin
         n_fail++; $display("FAIL return_idle: got ok=%b disp=%b cap=%b expected 1 1 1", ok, display_en, capture_en); end
   endtask

   task automatic test_mid_flush_change();
      logic ok, saw;
      logic [1:0] exp;
      int width;
      mode_req = 2'b11;
      exp_q.push_back(2'b10);
      wait_size(2'b01, 600, ok, saw);
      exp = exp_q.pop_front();
      n_checks++; if (!ok || size_select !== exp) begin n_fail++; $display("FAIL commit_11: got %b expected %b", size_select, exp); end
      measure_resend(width);
      cfg_handshake();
      wait_level(0, 1'b1, 600, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_capture: got timeout expected capture_en=1"); end
      mode_req = 2'b00;
      exp_q.push_back(2'b00);
      wait_level(3, 1'b0, 1500, ok);
      n_checks++; if (!ok || size_select !== 2'b10) begin n_fail++; $display("FAIL first_seq_size: got ok=%b size=%b expected 1 10", ok, size_select); end
      wait_size(2'b10, 600, ok, saw);
      exp = exp_q.pop_front();
      n_checks++; if (!ok || size_select !== exp) begin n_fail++; $display("FAIL second_commit: got %b expected %b", size_select, exp); end
      measure_resend(width);
      n_checks++; if (width != 4) begin n_fail++; $display("FAIL resend_width2: got %0d expected 4", width); end
      cfg_handshake();
      wait_level(3, 1'b0, 1500, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL second_idle: got timeout expected busy=0"); end
   endtask

   task automatic test_cfg_edge_pair();
      logic ok, saw, stuck;
      logic [1:0] exp;
      int width;
      mode_req = 2'b01;
      exp_q.push_back(2'b01);
      wait_size(2'b00, 600, ok, saw);
      exp = exp_q.pop_front();
      n_checks++; if (!ok || size_select !== exp) begin n_fail++; $display("FAIL commit_cfg: got %b expected %b", size_select, exp); end
      measure_resend(width);
      stuck = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (capture_en !== 1'b0 || busy !== 1'b1) stuck = 1'b1;
      end
      n_checks++; if (stuck) begin n_fail++; $display("FAIL cfg_hold_high: got left CFG_WAIT expected stay"); end
      config_finished = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (capture_en !== 1'b0) stuck = 1'b1;
      end
      n_checks++; if (stuck) begin n_fail++; $display("FAIL cfg_low: got capture during low expected 0"); end
      config_finished = 1'b1;
      wait_level(0, 1'b1, 400, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL cfg_rise_flush: got timeout expected capture_en=1"); end
      wait_level(3, 1'b0, 1500, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL cfg_idle: got timeout expected busy=0"); end
   endtask

   task automatic test_reset_mid_seq();
      logic ok, saw;
      logic [1:0] exp;
      mode_req = 2'b10;
      exp_q.push_back(2'b10);
      wait_size(2'b01, 600, ok, saw);
      exp = exp_q.pop_front();
      n_checks++; if (!ok || size_select !== exp || resend !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset: got size=%b resend=%b expected %b 1", size_select, resend, exp); end
      rst = 1'b1;
      mode_req = 2'b00;
      @(negedge clk);
      n_checks++; if (size_select !== 2'b00 || capture_en !== 1'b0 || display_en !== 1'b0 ||
                      resend !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset: got size=%b cap=%b disp=%b rs=%b busy=%b expected 00 0 0 0 1",
                            size_select, capture_en, display_en, resend, busy); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1 || capture_en !== 1'b0) begin
         n_fail++; $display("FAIL reinit: got busy=%b cap=%b expected 1 0", busy, capture_en); end
      wait_level(3, 1'b0, 1500, ok);
      n_checks++; if (!ok || size_select !== 2'b00 || display_en !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_idle: got ok=%b size=%b disp=%b expected 1 00 1", ok, size_select, display_en); end
   endtask

`ifdef RES_SEQ_CFG_TIMEOUT_EN
   task automatic test_cfg_timeout();
      logic ok, saw, prev;
      logic [1:0] exp;
      int pulses;
      mode_req = 2'b01;
      exp_q.push_back(2'b01);
      wait_size(2'b00, 600, ok, saw);
      exp = exp_q.pop_front();
      n_checks++; if (!ok || size_select !== exp) begin n_fail++; $display("FAIL commit_tmo: got %b expected %b", size_select, exp); end
      config_finished = 1'b0;
      pulses = 1;
      prev = resend;
      ok = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (resend && !prev) pulses++;
         prev = resend;
         if (cfg_error === 1'b1) begin ok = 1'b1; break; end
      end
      n_checks++; if (!ok) begin n_fail++; $display("FAIL cfg_error_set: got timeout expected cfg_error=1"); end
      n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL retry_pulses: got %0d expected 3", pulses); end
      wait_level(0, 1'b1, 500, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_flush: got timeout expected capture_en=1"); end
      config_finished = 1'b1;
      wait_level(3, 1'b0, 1500, ok);
      n_checks++; if (!ok || cfg_error !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got ok=%b err=%b expected 1 1", ok, cfg_error); end
   endtask
`endif

   initial begin
      test_reset();
      test_bringup();
      test_mode_change();
      test_mid_flush_change();
      test_cfg_edge_pair();
      test_reset_mid_seq();
`ifdef RES_SEQ_CFG_TIMEOUT_EN
      test_cfg_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
